// File: rtl/iob_reg_ibex_wr_arb_pkg.sv
// Shared definitions for the register write-port arbiter: FSM state encoding.
package iob_reg_ibex_wr_arb_pkg;

   // One write takes WRITE then ACK; one clear takes CLEAR then CDONE.
   // IDLE, ACK and CDONE are the states where a new decision is made.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      ACK   = 3'd2,
      CLEAR = 3'd3,
      CDONE = 3'd4
   } arbState_e;

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: finds the first eligible request
// starting one position after the pointer and wrapping around.
module iob_rr_pick #(
   parameter int N_REQ = 4,
   localparam int SEL_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   input  logic [N_REQ-1:0] mask_i,
   output logic             valid_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [N_REQ-1:0] eligible;

   // A masked requester cannot win, even if it is requesting.
   assign eligible = req_i & ~mask_i;

   // Scan from the farthest offset down to the nearest so that the last hit
   // written is the closest one after the pointer; this avoids a break.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         logic [SEL_W-1:0] candIdx;
         candIdx = SEL_W'((int'(ptr_i) + i) % N_REQ);
         if (eligible[candIdx]) begin
            valid_o = 1'b1;
            idx_o   = candIdx;
         end
      end
   end

endmodule

// File: rtl/iob_reg_ibex_wr_arb.sv
// Round-robin sequencer for the single write port of an enable/reset
// register. Serialises N_REQ writers and a high-priority clear request,
// and hands back one-cycle acknowledges once each value is committed.
module iob_reg_ibex_wr_arb
   import iob_reg_ibex_wr_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   localparam int SEL_W = $clog2(N_REQ)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*DATA_W-1:0] wdata_i,
   output logic [N_REQ-1:0]        ack_o,
   input  logic                    clr_i,
   output logic                    clr_done_o,
   output logic                    busy_o,
   output logic [SEL_W-1:0]        gnt_id_o,
   output logic                    reg_en_o,
   output logic                    reg_rst_o,
   output logic [DATA_W-1:0]       reg_data_o
);

   arbState_e         state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic              clrPend_q, clrPend_d;
   logic [SEL_W-1:0]  gntId_q, gntId_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [N_REQ-1:0]  ackVec;
   logic              pickValid;
   logic [SEL_W-1:0]  pickIdx;

   // The requester being acknowledged is also the one masked out of the
   // same cycle's arbitration, so a renewing requester yields to others.
   assign ackVec = (state_q == ACK) ? (N_REQ'(1) << gntId_q) : '0;

   iob_rr_pick #(
      .N_REQ (N_REQ)
   ) uPick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .mask_i  (ackVec),
      .valid_o (pickValid),
      .idx_o   (pickIdx)
   );

   // Next-state logic: clear beats writes, writes are granted round-robin,
   // and each operation is a fixed two-cycle sequence.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      clrPend_d = clrPend_q | clr_i;
      gntId_d   = gntId_q;
      data_d    = data_q;
      case (state_q)
         WRITE: state_d = ACK;
         CLEAR: state_d = CDONE;
         IDLE, ACK, CDONE: begin
            if (clrPend_q || clr_i) begin
               state_d   = CLEAR;
               clrPend_d = 1'b0;
            end else if (pickValid) begin
               state_d = WRITE;
               ptr_d   = pickIdx;
               gntId_d = pickIdx;
               data_d  = wdata_i[int'(pickIdx)*DATA_W +: DATA_W];
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; a low reset aborts any write or clear in progress.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= SEL_W'(N_REQ - 1);
         clrPend_q <= 1'b0;
         gntId_q   <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         clrPend_q <= clrPend_d;
         gntId_q   <= gntId_d;
         data_q    <= data_d;
      end
   end

   // Register-side outputs come straight from state, so en and rst can never
   // overlap; the data bus keeps its last value to avoid needless toggling.
   assign reg_en_o   = (state_q == WRITE);
   assign reg_rst_o  = (state_q == CLEAR);
   assign reg_data_o = data_q;
   assign ack_o      = ackVec;
   assign clr_done_o = (state_q == CDONE);
   assign busy_o     = (state_q != IDLE) | clrPend_q;
   assign gnt_id_o   = gntId_q;

endmodule

// File: tb/tb_iob_reg_ibex_wr_arb.sv
// Testbench for the register write-port arbiter. A timeline model predicts,
// for every cycle, which strobes fire and what the grant/data buses show.
module tb_iob_reg_ibex_wr_arb;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 2;

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ*DATA_W-1:0] wdata_i;
   logic [N_REQ-1:0]        ack_o;
   logic                    clr_i;
   logic                    clr_done_o;
   logic                    busy_o;
   logic [SEL_W-1:0]        gnt_id_o;
   logic                    reg_en_o;
   logic                    reg_rst_o;
   logic [DATA_W-1:0]       reg_data_o;

   iob_reg_ibex_wr_arb #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .wdata_i    (wdata_i),
      .ack_o      (ack_o),
      .clr_i      (clr_i),
      .clr_done_o (clr_done_o),
      .busy_o     (busy_o),
      .gnt_id_o   (gnt_id_o),
      .reg_en_o   (reg_en_o),
      .reg_rst_o  (reg_rst_o),
      .reg_data_o (reg_data_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int cyc        = 0;

   logic [N_REQ-1:0]  reqHeld = '0;
   logic [N_REQ-1:0]  renew   = '0;
   logic [DATA_W-1:0] dataOf [N_REQ];

   int ackLog[$];
   int doneCount = 0;

   // Model: cycle numbers at which each one-shot event is due, plus the
   // values the grant/data buses should show from the next cycle on.
   int                ptrM, arbAt, enAt, rstAt, ackAt, ackIdx, doneAt, gntM;
   bit                pendM, idleM;
   logic [DATA_W-1:0] dataM;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset(input int nextArb);
      ptrM   = N_REQ - 1;
      pendM  = 1'b0;
      idleM  = 1'b1;
      arbAt  = nextArb;
      enAt   = -1;
      rstAt  = -1;
      ackAt  = -1;
      doneAt = -1;
      ackIdx = 0;
      gntM   = 0;
      dataM  = '0;
   endtask

   task automatic modelUpdate();
      int  win;
      bit  found;
      if (!rst_ni) begin
         modelReset(cyc + 1);
      end else begin
         if (clr_i) pendM = 1'b1;
         if (cyc == arbAt) begin
            if (pendM) begin
               pendM  = 1'b0;
               rstAt  = cyc + 1;
               doneAt = cyc + 2;
               arbAt  = cyc + 2;
               idleM  = 1'b0;
            end else begin
               found = 1'b0;
               win   = 0;
               for (int k = 1; k <= N_REQ; k++) begin
                  int n;
                  n = (ptrM + k) % N_REQ;
                  if (!found && req_i[n] && !(cyc == ackAt && n == ackIdx)) begin
                     found = 1'b1;
                     win   = n;
                  end
               end
               if (found) begin
                  ptrM   = win;
                  gntM   = win;
                  dataM  = wdata_i[win*DATA_W +: DATA_W];
                  enAt   = cyc + 1;
                  ackAt  = cyc + 2;
                  ackIdx = win;
                  arbAt  = cyc + 2;
                  idleM  = 1'b0;
               end else begin
                  arbAt  = cyc + 1;
                  idleM  = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [N_REQ-1:0] expAck;
      expAck = (cyc == ackAt) ? (N_REQ'(1) << ackIdx) : '0;
      checkVal("ack",      ack_o,      expAck);
      checkVal("reg_en",   reg_en_o,   (cyc == enAt));
      checkVal("reg_rst",  reg_rst_o,  (cyc == rstAt));
      checkVal("clr_done", clr_done_o, (cyc == doneAt));
      checkVal("busy",     busy_o,     (!idleM || pendM));
      checkVal("gnt_id",   gnt_id_o,   gntM);
      checkVal("reg_data", reg_data_o, dataM);
      checkVal("en_rst_excl", reg_en_o & reg_rst_o, 0);
      checkVal("ack_onehot", ($countones(ack_o) <= 1), 1);
      for (int n = 0; n < N_REQ; n++) if (ack_o[n]) ackLog.push_back(n);
      if (clr_done_o) doneCount++;
   endtask

   task automatic applyStimulus(input bit clrV, input bit rstNV);
      @(negedge clk_i);
      checkOutput();
      for (int n = 0; n < N_REQ; n++)
         if (cyc == ackAt && ackIdx == n && !renew[n]) reqHeld[n] = 1'b0;
      rst_ni = rstNV;
      clr_i  = clrV;
      req_i  = reqHeld;
      for (int n = 0; n < N_REQ; n++) wdata_i[n*DATA_W +: DATA_W] = dataOf[n];
      modelUpdate();
      cyc++;
   endtask

   task automatic checkLog(input string tag, input int exp[$]);
      checkVal({tag, "_count"}, ackLog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < ackLog.size(); i++)
         checkVal({tag, "_order"}, ackLog[i], exp[i]);
      ackLog.delete();
   endtask

   // Directed scenarios first, then a randomized soak with the same model.
   initial begin
      int doneBase;
      for (int n = 0; n < N_REQ; n++) dataOf[n] = '0;
      rst_ni  = 1'b0;
      clr_i   = 1'b0;
      req_i   = '0;
      wdata_i = '0;
      modelReset(0);

      applyStimulus(0, 0);
      applyStimulus(0, 0);
      ackLog.delete();

      $display("[TB] single request");
      dataOf[2] = 32'hDEADBEEF;
      reqHeld   = 4'b0100;
      renew     = '0;
      repeat (4) applyStimulus(0, 1);
      checkLog("single", '{2});

      $display("[TB] all four requesting from reset");
      applyStimulus(0, 0);
      ackLog.delete();
      for (int n = 0; n < N_REQ; n++) dataOf[n] = $urandom;
      reqHeld = 4'b1111;
      renew   = 4'b1111;
      repeat (11) applyStimulus(0, 1);
      checkLog("rr_all", '{0, 1, 2, 3, 0});
      reqHeld = '0;
      renew   = '0;
      applyStimulus(0, 0);
      ackLog.delete();

      $display("[TB] clear and request together");
      doneBase  = doneCount;
      dataOf[1] = 32'h1234_5678;
      reqHeld   = 4'b0010;
      applyStimulus(1, 1);
      repeat (5) applyStimulus(0, 1);
      checkLog("clr_then_req", '{1});
      checkVal("clr_then_req_done", doneCount - doneBase, 1);

      $display("[TB] clear pulses during write");
      doneBase  = doneCount;
      dataOf[3] = 32'hCAFE_F00D;
      reqHeld   = 4'b1000;
      applyStimulus(0, 1);
      applyStimulus(1, 1);
      applyStimulus(1, 1);
      repeat (4) applyStimulus(0, 1);
      checkLog("clr_in_write", '{3});
      checkVal("clr_merge_done", doneCount - doneBase, 1);

      $display("[TB] reset during write");
      reqHeld = 4'b0010;
      applyStimulus(0, 1);
      applyStimulus(0, 0);
      reqHeld = 4'b1001;
      repeat (6) applyStimulus(0, 1);
      checkLog("rst_abort", '{0, 3});

      $display("[TB] renewing requester yields");
      reqHeld = 4'b0001;
      renew   = 4'b0001;
      applyStimulus(0, 1);
      reqHeld[2] = 1'b1;
      repeat (4) applyStimulus(0, 1);
      renew = '0;
      repeat (4) applyStimulus(0, 1);
      checkLog("fairness", '{0, 2, 0});

      $display("[TB] randomized traffic");
      for (int c = 0; c < 800; c++) begin
         for (int n = 0; n < N_REQ; n++) begin
            if (!reqHeld[n] && ($urandom_range(0, 99) < 30)) begin
               reqHeld[n] = 1'b1;
               dataOf[n]  = $urandom;
            end
         end
         renew = N_REQ'($urandom);
         applyStimulus(($urandom_range(0, 99) < 5), !($urandom_range(0, 99) < 1));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
